sorter_pipelined_nway: RTL
==========================

Name: sorter_pipelined_nway

Overview:
- Parametrised, fully pipelined N-input sorter using an odd-even transposition network.
- Successor to the fixed 3-input, 8-bit ascending sorter. Generalised in lane count N and data width.
- Adds valid/ready flow control with backpressure, per-sample ascending/descending mode, a signed-compare option and a direct median output.
- Core kernel of the median-filter datapath: N=3 serves row/column sorting; N=9 serves a full 3x3 window median.

Parameters:
- WIDTH, 8: bits per lane.
- N, 3: number of lanes. Legal range 2..16; must be odd when out_median is used.
- SIGNED, 0: 0 = unsigned compare, 1 = two's-complement compare.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  N*WIDTH  unsorted lanes; lane i occupies bits [i*WIDTH +: WIDTH].
- in_desc  in  1  0 = ascending, 1 = descending; captured with the sample.
- out_valid  out  1  out_data and out_median hold a sorted result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  N*WIDTH  sorted lanes. Lane 0 is the min when ascending, the max when descending.
- out_median  out  WIDTH  lane N/2 (integer division) of the sorted result.

Behaviour:
- One clock; reset is synchronous and active-high.
- Pipeline: N register stages, s = 0..N-1.
  - Stage s applies compare-exchange to lane pairs (j, j+1).
  - Even s: j even. Odd s: j odd.
  - Unpaired edge lanes pass through unchanged.
  - Stage 0 operates on in_data directly. Stage N-1 registers drive out_data.
- Each stage carries its own valid bit and desc bit alongside the data.
- Compare-exchange:
  - Ascending: swap when lane[j] > lane[j+1].
  - Descending: swap when lane[j] < lane[j+1].
  - Equal values are never swapped.
  - Comparison is signed when SIGNED=1, otherwise unsigned. No arithmetic, so no width growth.
- Advance condition: advance = !out_valid || out_ready.
  - When advance=1, every stage loads from its predecessor.
  - When advance=0, all stages (data, valid, desc) hold.
- in_ready = advance && !rst.
  - A sample is accepted when in_valid && in_ready.
  - If advance=1 and in_valid=0, a bubble (valid=0) enters stage 0.
- Latency: a sample accepted in cycle c appears with out_valid=1 in cycle c+N, provided advance stayed 1. Each cycle of advance=0 adds one cycle.
- Throughput: one sample per cycle with out_ready held high.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_median and out_valid stay stable until the handshake completes.
- in_desc and in_data are sampled only on acceptance. Mode switches between consecutive samples take effect per sample, with no flush.
- Reset values:
  - all stage valid bits 0, hence out_valid=0.
  - all stage data 0, hence out_data=0 and out_median=0.
  - all desc bits 0.
  - in_ready=0 during rst; in_ready=1 in the first cycle after rst deasserts.
- Reset mid-operation: all in-flight samples are discarded and never emerge. There is no partial output.
- Simultaneous events:
  - With out_valid && out_ready && in_valid, the output retires and the new sample enters in the same cycle.
  - rst overrides every handshake.
- Synthesis-time elaboration error if N<2.

Decomposition:
- Shared package sorter_pkg holds:
  - function cmp_gt(a, b, signed_mode) for the compare.
  - the lane-slice helper.
  - constants for the default WIDTH and N.
- One sub-module, sorter_cmp_swap: combinational compare-exchange.
  - Inputs: a, b, desc. Outputs: lo_out, hi_out. Parameters: WIDTH, SIGNED.
  - Instanced per pair per stage through generate loops.
- The stage register array and valid/desc shift chain live in the top module.

Test Plan:
- N=3, W=8, asc: accept {lane0=7, lane1=200, lane2=42} in cycle c -> cycle c+3: out_data={7,42,200}, out_median=42, out_valid=1.
- N=3, desc: accept {7,200,42} -> out_data={200,42,7}, out_median=42. Then send back-to-back asc/desc/asc samples with out_ready=1 -> each sample sorted per its own mode, one result per cycle.
- Backpressure: stream 6 samples, drop out_ready for 4 cycles mid-stream -> out_data stable while stalled, in_ready=0 during the stall, all 6 results delivered in order, none duplicated or lost.
- Reset: assert rst for 1 cycle while 2 samples are in flight -> out_valid=0 and out_data=0 the next cycle, the in-flight samples never appear, and a new sample accepted afterwards has correct latency.
- N=9, W=8: window {9,1,8,2,7,3,6,4,5} -> cycle c+9: out_median=5, out_data ascending 1..9. Equal values {4,4,4,...} -> all lanes 4.
- SIGNED=1, N=3: {8'hFF, 8'h01, 8'h80} asc -> {8'h80, 8'hFF, 8'h01}. The same stimulus with SIGNED=0 -> {8'h01, 8'h80, 8'hFF}.

Source files
------------

// File: rtl/sorter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sorter_pkg                                                               |
// | Shared compare helper, lane-slice helper and default sizing constants.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package sorter_pkg;

    localparam int c_DEFAULT_WIDTH = 8;
    localparam int c_DEFAULT_N     = 3;
    localparam int c_CMP_MAX_WIDTH = 64;

    // Operands arrive already extended to c_CMP_MAX_WIDTH, sign- or zero-filled to match signed_mode.
    function automatic logic cmp_gt(
        input logic [c_CMP_MAX_WIDTH-1:0] a,
        input logic [c_CMP_MAX_WIDTH-1:0] b,
        input logic                       signed_mode
    );
        logic w_gt;
        if (signed_mode) begin
            w_gt = $signed(a) > $signed(b);
        end else begin
            w_gt = a > b;
        end
        return w_gt;
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sorter_cmp_swap.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sorter_cmp_swap                                                          |
// | Combinational compare-exchange of one lane pair; equal values stay put.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sorter_cmp_swap
    import sorter_pkg::*;
#(
    parameter int WIDTH  = c_DEFAULT_WIDTH,
    parameter bit SIGNED = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             desc,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] hi_out
);

    logic [c_CMP_MAX_WIDTH-1:0] w_a_ext;
    logic [c_CMP_MAX_WIDTH-1:0] w_b_ext;
    logic                       w_swap;

    generate
        if (WIDTH > c_CMP_MAX_WIDTH) begin : g_width_check
            $error("sorter_cmp_swap: WIDTH exceeds c_CMP_MAX_WIDTH");
        end

        if (SIGNED) begin : g_sext
            assign w_a_ext = c_CMP_MAX_WIDTH'($signed(a));
            assign w_b_ext = c_CMP_MAX_WIDTH'($signed(b));
        end else begin : g_zext
            assign w_a_ext = c_CMP_MAX_WIDTH'(a);
            assign w_b_ext = c_CMP_MAX_WIDTH'(b);
        end
    endgenerate

    assign w_swap = desc ? cmp_gt(w_b_ext, w_a_ext, SIGNED)
                         : cmp_gt(w_a_ext, w_b_ext, SIGNED);

    assign lo_out = w_swap ? b : a;
    assign hi_out = w_swap ? a : b;

endmodule
`default_nettype wire

// File: rtl/sorter_pipelined_nway.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sorter_pipelined_nway                                                    |
// | N-stage odd-even transposition sorter with valid/ready and median tap.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sorter_pipelined_nway
    import sorter_pkg::*;
#(
    parameter int WIDTH  = c_DEFAULT_WIDTH,
    parameter int N      = c_DEFAULT_N,
    parameter bit SIGNED = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic                 in_desc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WIDTH-1:0]   out_data,
    output logic [WIDTH-1:0]     out_median
);

    logic [WIDTH-1:0] r_lane     [N][N];
    logic [WIDTH-1:0] w_lane_in  [N][N];
    logic [WIDTH-1:0] w_lane_out [N][N];
    logic [N-1:0]     r_valid;
    // The last stage's mode is never consumed, so the chain stops one short.
    logic [N-2:0]     r_desc;
    logic [N-1:0]     w_stage_desc;
    logic             w_advance;

    assign w_advance = !r_valid[N-1] || out_ready;
    assign in_ready  = w_advance && !rst;

    generate
        if (N < 2) begin : g_n_check
            $error("sorter_pipelined_nway: N must be at least 2");
        end

        for (genvar s = 0; s < N; s++) begin : g_stage
            if (s == 0) begin : g_first
                assign w_stage_desc[s] = in_desc;
                for (genvar j = 0; j < N; j++) begin : g_in
                    assign w_lane_in[s][j] = in_data[lane_lsb(j, WIDTH) +: WIDTH];
                end
            end else begin : g_next
                assign w_stage_desc[s] = r_desc[s-1];
                for (genvar j = 0; j < N; j++) begin : g_in
                    assign w_lane_in[s][j] = r_lane[s-1][j];
                end
            end

            for (genvar j = 0; j < N; j++) begin : g_lane
                if (((j % 2) == (s % 2)) && ((j + 1) < N)) begin : g_pair
                    sorter_cmp_swap #(
                        .WIDTH  (WIDTH),
                        .SIGNED (SIGNED)
                    ) u_cmp_swap (
                        .a      (w_lane_in[s][j]),
                        .b      (w_lane_in[s][j+1]),
                        .desc   (w_stage_desc[s]),
                        .lo_out (w_lane_out[s][j]),
                        .hi_out (w_lane_out[s][j+1])
                    );
                end else if (!((j >= 1) && (((j - 1) % 2) == (s % 2)))) begin : g_pass
                    assign w_lane_out[s][j] = w_lane_in[s][j];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_desc  <= '0;
            for (int s = 0; s < N; s++) begin
                for (int j = 0; j < N; j++) begin
                    r_lane[s][j] <= '0;
                end
            end
        end else if (w_advance) begin
            r_valid[0] <= in_valid;
            r_desc[0]  <= in_desc;
            for (int s = 1; s < N; s++) begin
                r_valid[s] <= r_valid[s-1];
            end
            for (int s = 1; s < N - 1; s++) begin
                r_desc[s] <= r_desc[s-1];
            end
            for (int s = 0; s < N; s++) begin
                for (int j = 0; j < N; j++) begin
                    r_lane[s][j] <= w_lane_out[s][j];
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int j = 0; j < N; j++) begin
            out_data[lane_lsb(j, WIDTH) +: WIDTH] = r_lane[N-1][j];
        end
    end

    assign out_valid  = r_valid[N-1];
    assign out_median = r_lane[N-1][N/2];

endmodule
`default_nettype wire
